intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller sitting directly upstream of the interrupt vector encoder.
- Detects rising edges on 8 interrupt lines and latches them as pending, applying a per-line mask and a global enable.
- Presents one one-hot, frozen selection vector to the encoder and runs a request/acknowledge/return handshake with the CPU control unit.
- Bit 0 has the highest priority, matching the encoder's priority order.

Parameters:
- N_IRQ, 8: number of interrupt lines; fixed at 8 because the vector encoder is 8 inputs wide.
- MASK_RST, 8'h00: mask register value after reset; 0 means masked.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-high.
- irq_in  input  8  interrupt lines, synchronous to clk; an event is a 0->1 transition.
- mask_we  input  1  write strobe for the mask register.
- mask_in  input  8  new mask value; 1 enables the line.
- ei  input  1  global interrupt enable set (EI instruction).
- di  input  1  global interrupt enable clear (DI instruction).
- intr_ack  input  1  CPU has taken the interrupt and jumped to the vector.
- intr_ret  input  1  CPU executed the return-from-interrupt.
- intr_req  output  1  interrupt request to the CPU control unit.
- intr_selec  output  8  one-hot selected line, fed to the vector encoder.
- pending  output  8  pending register, for debug and status.
- in_service  output  1  high while a handler is running.
- gie  output  1  current global enable.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - pending=0, mask=MASK_RST, gie=0, state=IDLE.
  - intr_req=0, intr_selec=0, in_service=0.
  - Edge-history register loads irq_in, so lines already high during reset create no event.
  - Reset overrides every other input in the same cycle, including during REQ or SVC.
- Edge detect: evt = irq_in & ~prev; prev <= irq_in every cycle.
- Pending update: pending <= (pending & ~clr) | evt.
  - clr is the one-hot of the acknowledged line, non-zero only on the ack cycle.
  - A new event on the line being cleared wins: the bit stays set.
  - Masked lines still latch pending; they are only excluded from arbitration.
- Mask and enable:
  - mask <= mask_in when mask_we.
  - gie: di wins over ei; otherwise ei sets gie, di clears it.
  - gie is cleared automatically on ack.
- Arbitration: cand = pending & mask; win = lowest set bit of cand, as a one-hot.
- State machine, all outputs registered:
  - IDLE, intr_req=0, intr_selec=0:
    - If gie && cand != 0: go to REQ; intr_selec <= win; intr_req <= 1.
  - REQ, intr_req=1, intr_selec frozen (no preemption by a higher-priority line):
    - If intr_ack: clear that pending bit, gie <= 0, go to SVC, intr_req <= 0, intr_selec <= 0, in_service <= 1.
    - Else if gie==0 or the selected bit is now masked: retract to IDLE; intr_req <= 0, intr_selec <= 0.
    - intr_ack takes precedence over a retraction in the same cycle.
  - SVC, in_service=1:
    - No nesting; new events keep latching as pending.
    - On intr_ret: in_service <= 0, gie <= 1, go to IDLE.
    - Rearbitration happens from IDLE on the following edge.
- Latency:
  - irq_in rises and is sampled high at edge k: pending bit set after edge k.
  - intr_req and intr_selec valid after edge k+1, provided gie=1 and the line is unmasked.
- Ignored inputs: intr_ack outside REQ; intr_ret outside SVC.
- Invariants:
  - intr_selec is one-hot exactly when intr_req=1, and 0 otherwise.
  - The encoder output is don't-care when intr_req=0.

Test Plan:
1. Reset with irq_in=8'h04 held high; mask=8'hFF; ei -> no pending, intr_req stays 0; a later 0->1 on bit 2 gives pending=8'h04, then intr_req=1 and intr_selec=8'h04 one cycle later.
2. Priority: gie=1, mask=8'hFF, irq_in 0->8'h28 in one cycle -> intr_selec=8'h08; ack -> pending=8'h20, in_service=1; intr_ret -> next cycle IDLE, following cycle intr_selec=8'h20.
3. Masking: mask=8'hFE, event on bit 0 -> pending=8'h01, intr_req=0; then mask_we with 8'hFF -> intr_req=1, intr_selec=8'h01.
4. Retraction: in REQ with intr_selec=8'h02, assert di (no ack) -> intr_req=0, intr_selec=0, pending still 8'h02; di and ack in the same cycle -> ack wins, state SVC.
5. Simultaneous set/clear: ack on line 3 in the same cycle as a new 0->1 on irq_in[3] -> pending[3] remains 1; after intr_ret, line 3 is requested again.
6. Reset mid-service: in SVC with pending=8'h10, assert reset -> all outputs 0, pending=0, gie=0, mask=8'h00 next cycle.

Source files
------------

// File: rtl/intr_ctrl.sv
// intr_ctrl: 8-line rising-edge interrupt controller feeding the vector encoder.
// Latency: an edge sampled at clock k sets pending after k; a request appears after k+1.
// Backpressure: a selection stays frozen in REQ until intr_ack, or until it is retracted because of gie or the mask.
//
// Ports:
//   clk, reset           : clock and synchronous active-high reset
//   irq_in[7:0]          : interrupt lines; a 0->1 transition is an event
//   mask_we, mask_in     : mask register write (1 = line enabled)
//   ei, di               : global enable set / clear (di wins)
//   intr_ack, intr_ret   : CPU handshake (taken / returned)
//   intr_req, intr_selec : registered request and one-hot selected line
//   pending, in_service, gie : status

module intr_ctrl #(
  parameter int unsigned N_IRQ    = 8,
  parameter logic [7:0]  MASK_RST = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             ei,
  input  logic             di,
  input  logic             intr_ack,
  input  logic             intr_ret,
  output logic             intr_req,
  output logic [N_IRQ-1:0] intr_selec,
  output logic [N_IRQ-1:0] pending,
  output logic             in_service,
  output logic             gie
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic             gie_q, gie_d;
  logic             intr_req_q, intr_req_d;
  logic [N_IRQ-1:0] intr_selec_q, intr_selec_d;
  logic             in_service_q, in_service_d;

  logic [N_IRQ-1:0] evt;
  logic [N_IRQ-1:0] cand;
  logic [N_IRQ-1:0] win;
  logic [N_IRQ-1:0] clr;

  always_comb begin
    evt  = irq_in & ~prev_q;
    cand = pending_q & mask_q;
    // Two's-complement trick isolates the lowest set bit (bit 0 = highest priority).
    win  = cand & (~cand + N_IRQ'(1));

    state_d      = state_q;
    prev_d       = irq_in;
    mask_d       = mask_we ? mask_in : mask_q;
    intr_req_d   = intr_req_q;
    intr_selec_d = intr_selec_q;
    in_service_d = in_service_q;
    clr          = '0;

    if (di)      gie_d = 1'b0;
    else if (ei) gie_d = 1'b1;
    else         gie_d = gie_q;

    case (state_q)
      ST_IDLE: begin
        if (gie_q && (cand != '0)) begin
          state_d      = ST_REQ;
          intr_req_d   = 1'b1;
          intr_selec_d = win;
        end
      end
      ST_REQ: begin
        // Ack beats retraction; the selection is never preempted.
        if (intr_ack) begin
          clr          = intr_selec_q;
          gie_d        = 1'b0;
          state_d      = ST_SVC;
          intr_req_d   = 1'b0;
          intr_selec_d = '0;
          in_service_d = 1'b1;
        end else if (!gie_q || ((intr_selec_q & mask_q) == '0)) begin
          state_d      = ST_IDLE;
          intr_req_d   = 1'b0;
          intr_selec_d = '0;
        end
      end
      ST_SVC: begin
        if (intr_ret) begin
          in_service_d = 1'b0;
          gie_d        = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        intr_req_d   = 1'b0;
        intr_selec_d = '0;
        in_service_d = 1'b0;
      end
    endcase

    // A fresh event on the line being cleared keeps the bit set.
    pending_d = (pending_q & ~clr) | evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_q       <= irq_in;  // lines already high at reset raise no event
      pending_q    <= '0;
      mask_q       <= MASK_RST[N_IRQ-1:0];
      gie_q        <= 1'b0;
      intr_req_q   <= 1'b0;
      intr_selec_q <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      gie_q        <= gie_d;
      intr_req_q   <= intr_req_d;
      intr_selec_q <= intr_selec_d;
      in_service_q <= in_service_d;
    end
  end

  assign intr_req   = intr_req_q;
  assign intr_selec = intr_selec_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign gie        = gie_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed self-checking bench for intr_ctrl.
// Latency: inputs driven 1 time unit after a rising edge, outputs checked 1 time unit after the next one.
// Backpressure: none; the bench plays the CPU side of the handshake directly.

module tb_intr_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       ei, di, intr_ack, intr_ret;
  logic       intr_req;
  logic [7:0] intr_selec;
  logic [7:0] pending;
  logic       in_service;
  logic       gie;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  intr_ctrl #(.N_IRQ(8), .MASK_RST(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .ei         (ei),
    .di         (di),
    .intr_ack   (intr_ack),
    .intr_ret   (intr_ret),
    .intr_req   (intr_req),
    .intr_selec (intr_selec),
    .pending    (pending),
    .in_service (in_service),
    .gie        (gie)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ack then return the currently requested line, leaving gie=1 in IDLE.
  task automatic service();
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    intr_ret = 1'b1; tick(); intr_ret = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; irq_in = 8'h04; mask_we = 1'b0; mask_in = 8'h00;
    ei = 1'b0; di = 1'b0; intr_ack = 1'b0; intr_ret = 1'b0;
    tick(); tick();
    n_tests++;
    if ({intr_req, intr_selec, pending, in_service, gie} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b selec=%h pend=%h insvc=%b gie=%b, want all 0",
               intr_req, intr_selec, pending, in_service, gie);
    end
    reset = 1'b0; mask_we = 1'b1; mask_in = 8'hFF; ei = 1'b1;
    tick();
    mask_we = 1'b0; ei = 1'b0;
    n_tests++;
    if (pending !== 8'h00 || gie !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held_line: pend=%h gie=%b, want 00 1", pending, gie);
    end
    tick();
    n_tests++;
    if (intr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_req: req=%b, want 0", intr_req);
    end
    irq_in = 8'h00; tick();
    irq_in = 8'h04; tick();
    n_tests++;
    if (pending !== 8'h04 || intr_req !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_latency_pend: pend=%h req=%b, want 04 0", pending, intr_req);
    end
    tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h04) begin
      n_fail++;
      $display("FAIL edge_latency_req: req=%b selec=%h, want 1 04", intr_req, intr_selec);
    end
    service();
    irq_in = 8'h00;
  endtask

  task automatic test_priority();
    irq_in = 8'h28; tick();
    n_tests++;
    if (pending !== 8'h28) begin
      n_fail++;
      $display("FAIL prio_pend: pend=%h, want 28", pending);
    end
    tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h08) begin
      n_fail++;
      $display("FAIL prio_sel: req=%b selec=%h, want 1 08", intr_req, intr_selec);
    end
    intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    n_tests++;
    if (pending !== 8'h20 || in_service !== 1'b1 || intr_req !== 1'b0 || gie !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ack: pend=%h insvc=%b req=%b gie=%b, want 20 1 0 0",
               pending, in_service, intr_req, gie);
    end
    intr_ret = 1'b1; tick(); intr_ret = 1'b0;
    n_tests++;
    if (in_service !== 1'b0 || intr_req !== 1'b0 || gie !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_ret: insvc=%b req=%b gie=%b, want 0 0 1", in_service, intr_req, gie);
    end
    tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h20) begin
      n_fail++;
      $display("FAIL prio_rearb: req=%b selec=%h, want 1 20", intr_req, intr_selec);
    end
    service();
    irq_in = 8'h00;
  endtask

  task automatic test_masking();
    mask_we = 1'b1; mask_in = 8'hFE; tick(); mask_we = 1'b0;
    irq_in = 8'h01; tick();
    n_tests++;
    if (pending !== 8'h01) begin
      n_fail++;
      $display("FAIL mask_pend: pend=%h, want 01", pending);
    end
    tick(); tick();
    n_tests++;
    if (intr_req !== 1'b0 || intr_selec !== 8'h00) begin
      n_fail++;
      $display("FAIL mask_blocked: req=%b selec=%h, want 0 00", intr_req, intr_selec);
    end
    mask_we = 1'b1; mask_in = 8'hFF; tick(); mask_we = 1'b0;
    tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h01) begin
      n_fail++;
      $display("FAIL mask_unmask: req=%b selec=%h, want 1 01", intr_req, intr_selec);
    end
    service();
    irq_in = 8'h00;
  endtask

  task automatic test_retraction();
    irq_in = 8'h02; tick(); tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h02) begin
      n_fail++;
      $display("FAIL retr_setup: req=%b selec=%h, want 1 02", intr_req, intr_selec);
    end
    di = 1'b1; tick(); di = 1'b0;
    tick();
    n_tests++;
    if (intr_req !== 1'b0 || intr_selec !== 8'h00 || pending !== 8'h02 || gie !== 1'b0) begin
      n_fail++;
      $display("FAIL retr_di: req=%b selec=%h pend=%h gie=%b, want 0 00 02 0",
               intr_req, intr_selec, pending, gie);
    end
    ei = 1'b1; tick(); ei = 1'b0;
    tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h02) begin
      n_fail++;
      $display("FAIL retr_rereq: req=%b selec=%h, want 1 02", intr_req, intr_selec);
    end
    di = 1'b1; intr_ack = 1'b1; tick(); di = 1'b0; intr_ack = 1'b0;
    n_tests++;
    if (in_service !== 1'b1 || intr_req !== 1'b0 || pending !== 8'h00 || gie !== 1'b0) begin
      n_fail++;
      $display("FAIL retr_ack_wins: insvc=%b req=%b pend=%h gie=%b, want 1 0 00 0",
               in_service, intr_req, pending, gie);
    end
    intr_ret = 1'b1; tick(); intr_ret = 1'b0;
    irq_in = 8'h00;
  endtask

  task automatic test_back_to_back();
    irq_in = 8'h08; tick(); tick();
    irq_in = 8'h00; tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h08) begin
      n_fail++;
      $display("FAIL b2b_setup: req=%b selec=%h, want 1 08", intr_req, intr_selec);
    end
    irq_in = 8'h08; intr_ack = 1'b1; tick(); intr_ack = 1'b0;
    n_tests++;
    if (pending !== 8'h08 || in_service !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_setclr: pend=%h insvc=%b, want 08 1", pending, in_service);
    end
    intr_ret = 1'b1; tick(); intr_ret = 1'b0;
    tick();
    n_tests++;
    if (intr_req !== 1'b1 || intr_selec !== 8'h08) begin
      n_fail++;
      $display("FAIL b2b_rereq: req=%b selec=%h, want 1 08", intr_req, intr_selec);
    end
    service();
    irq_in = 8'h00;
  endtask

  task automatic test_reset_mid_service();
    irq_in = 8'h10; tick(); tick();
    intr_ack = 1'b1; irq_in = 8'h00; tick(); intr_ack = 1'b0;
    irq_in = 8'h10; tick();
    n_tests++;
    if (pending !== 8'h10 || in_service !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_svc_setup: pend=%h insvc=%b, want 10 1", pending, in_service);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_tests++;
    if ({intr_req, intr_selec, pending, in_service, gie} !== 19'h0) begin
      n_fail++;
      $display("FAIL rst_svc_outputs: req=%b selec=%h pend=%h insvc=%b gie=%b, want all 0",
               intr_req, intr_selec, pending, in_service, gie);
    end
    // Mask should be back to 00: an event with gie=1 must not be requested.
    ei = 1'b1; irq_in = 8'h00; tick(); ei = 1'b0;
    irq_in = 8'h01; tick(); tick(); tick();
    n_tests++;
    if (pending !== 8'h01 || intr_req !== 1'b0 || gie !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_svc_mask: pend=%h req=%b gie=%b, want 01 0 1", pending, intr_req, gie);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_masking();
    test_retraction();
    test_back_to_back();
    test_reset_mid_service();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
